// File: rtl/am_pkg.sv
// am_pkg: shared constants and types for the associative-memory inference controller.
package am_pkg;
    localparam int NUM_CLASSES = 26;
    localparam int DIM         = 5000;
    localparam int CHUNK_W     = 500;
    localparam int SIM_W       = 13;
    localparam int CLASS_W     = 5;
    localparam int ADDR_W      = 9;
    localparam int NUM_CHUNKS  = DIM / CHUNK_W;
    localparam int NUM_RD      = NUM_CLASSES * NUM_CHUNKS;
    localparam int CHUNK_IDX_W = 4;
    typedef logic [SIM_W-1:0] sim_t;
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, INFER, CAPTURE, DONE} am_ctrl_state_t;
endpackage

// File: rtl/am_chunk_popcount.sv
// am_chunk_popcount: number of agreeing bits between two CHUNK_W-bit words.
module am_chunk_popcount
    import am_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    output sim_t               count
);
    logic [CHUNK_W-1:0] same;
    assign same = ~(a ^ b);
    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK_W; i++) count = count + sim_t'(same[i]);
    end
endmodule

// File: rtl/am_inference_ctrl.sv
// am_inference_ctrl: streams query and class HVs from the AM, scores each class,
// triggers the comparator and returns the winning class over valid/ready.
module am_inference_ctrl
    import am_pkg::*;
(
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             start,
    output logic                             busy,
    output logic [CHUNK_IDX_W-1:0]           query_chunk_idx,
    input  logic [CHUNK_W-1:0]               query_chunk,
    output logic                             am_rd_en,
    output logic [ADDR_W-1:0]                am_rd_addr,
    input  logic [CHUNK_W-1:0]               am_rd_data,
    output sim_t [NUM_CLASSES-1:0]           similarity_values,
    output logic                             inferring_class,
    input  logic [CLASS_W-1:0]               class_inference,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [CLASS_W-1:0]               result_class
);
    am_ctrl_state_t     state;
    logic [CLASS_W-1:0] cls;
    logic [CLASS_W-1:0] rsp_cls;
    logic               rsp_valid;
    logic               rsp_last;
    logic               chunk_end;
    sim_t               acc;
    sim_t               pc;

    assign chunk_end = query_chunk_idx == CHUNK_IDX_W'(NUM_CHUNKS - 1);

    am_chunk_popcount u_popcount (.a(query_chunk), .b(am_rd_data), .count(pc));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state             <= IDLE;
            busy              <= 1'b0;
            query_chunk_idx   <= '0;
            am_rd_en          <= 1'b0;
            am_rd_addr        <= '0;
            similarity_values <= '0;
            inferring_class   <= 1'b0;
            result_valid      <= 1'b0;
            result_class      <= '0;
            cls               <= '0;
            rsp_cls           <= '0;
            rsp_valid         <= 1'b0;
            rsp_last          <= 1'b0;
            acc               <= '0;
        end else begin
            // Response stage trails the read issue by one cycle to match SRAM latency.
            rsp_valid <= am_rd_en;
            rsp_cls   <= cls;
            rsp_last  <= chunk_end;
            if (rsp_valid) begin
                if (rsp_last) begin
                    similarity_values[rsp_cls] <= acc + pc;
                    acc                        <= '0;
                end else begin
                    acc <= acc + pc;
                end
            end
            case (state)
                IDLE: if (start) begin
                    state             <= FETCH;
                    busy              <= 1'b1;
                    am_rd_en          <= 1'b1;
                    am_rd_addr        <= '0;
                    query_chunk_idx   <= '0;
                    cls               <= '0;
                    acc               <= '0;
                    similarity_values <= '0;
                end
                FETCH: if (am_rd_addr == ADDR_W'(NUM_RD - 1)) begin
                    state    <= DRAIN;
                    am_rd_en <= 1'b0;
                end else begin
                    am_rd_addr      <= am_rd_addr + 1'b1;
                    query_chunk_idx <= chunk_end ? '0 : query_chunk_idx + 1'b1;
                    cls             <= chunk_end ? cls + 1'b1 : cls;
                end
                DRAIN: begin
                    state           <= INFER;
                    inferring_class <= 1'b1;
                end
                INFER: begin
                    state           <= CAPTURE;
                    inferring_class <= 1'b0;
                end
                CAPTURE: begin
                    state        <= DONE;
                    result_class <= class_inference;
                    result_valid <= 1'b1;
                end
                DONE: if (result_ready) begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_am_inference_ctrl.sv
// tb_am_inference_ctrl: random and directed HV scenarios scored by a whole-vector
// reference model, with SRAM, query buffer and comparator modelled around the DUT.
module tb_am_inference_ctrl;
    import am_pkg::*;

    localparam int M_RAND = 0, M_COPY = 1, M_TIE = 2, M_NEAR = 3;

    typedef struct {
        int mode;
        int a;
        int b;
        int exp_class;
        int exp_sim;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   nrst = 1'b0;
    logic                   start = 1'b0;
    logic                   busy;
    logic [CHUNK_IDX_W-1:0] query_chunk_idx;
    logic [CHUNK_W-1:0]     query_chunk = '0;
    logic                   am_rd_en;
    logic [ADDR_W-1:0]      am_rd_addr;
    logic [CHUNK_W-1:0]     am_rd_data = '0;
    sim_t [NUM_CLASSES-1:0] similarity_values;
    logic                   inferring_class;
    logic [CLASS_W-1:0]     class_inference = '0;
    logic                   result_valid;
    logic                   result_ready = 1'b1;
    logic [CLASS_W-1:0]     result_class;

    logic [DIM-1:0] q;
    logic [DIM-1:0] hv [NUM_CLASSES];
    int m_sim [NUM_CLASSES];
    int m_class;
    int errors = 0;
    int checks = 0;
    vec_t vecs [6];
    int rd_cnt, first_rd, addr_err, inf_cnt, inf_cyc, rv_cyc, rd2_cyc, n, stray;

    am_inference_ctrl dut (
        .clk(clk), .nrst(nrst), .start(start), .busy(busy),
        .query_chunk_idx(query_chunk_idx), .query_chunk(query_chunk),
        .am_rd_en(am_rd_en), .am_rd_addr(am_rd_addr), .am_rd_data(am_rd_data),
        .similarity_values(similarity_values), .inferring_class(inferring_class),
        .class_inference(class_inference), .result_valid(result_valid),
        .result_ready(result_ready), .result_class(result_class)
    );

    always #5 clk = ~clk;

    // Environment: 1-cycle SRAM, query buffer, and lowest-index-wins comparator.
    always @(posedge clk) begin
        if (am_rd_en)
            am_rd_data <= hv[int'(am_rd_addr) / NUM_CHUNKS][(int'(am_rd_addr) % NUM_CHUNKS) * CHUNK_W +: CHUNK_W];
        query_chunk <= q[int'(query_chunk_idx) * CHUNK_W +: CHUNK_W];
    end

    always @(posedge clk) begin
        int best;
        if (inferring_class) begin
            best = 0;
            for (int c = 1; c < NUM_CLASSES; c++)
                if (similarity_values[c] > similarity_values[best]) best = c;
            class_inference <= CLASS_W'(best);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [DIM-1:0] rand_hv();
        logic [DIM-1:0] v;
        for (int i = 0; i < DIM; i++) v[i] = 1'($urandom);
        return v;
    endfunction

    task automatic setup(input int mode, input int a, input int b);
        q = rand_hv();
        for (int c = 0; c < NUM_CLASSES; c++) hv[c] = rand_hv();
        if (mode == M_COPY) hv[a] = q;
        if (mode == M_TIE) begin
            q = '1;
            for (int c = 0; c < NUM_CLASSES; c++) hv[c] = '0;
            hv[a] = '1;
            hv[b] = '1;
        end
        if (mode == M_NEAR) begin
            for (int c = 0; c < NUM_CLASSES; c++) hv[c] = ~q;
            hv[a] = q;
            hv[a][99:0] = ~q[99:0];
        end
        m_class = 0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            m_sim[c] = $countones(~(q ^ hv[c]));
            if (m_sim[c] > m_sim[m_class]) m_class = c;
        end
    endtask

    task automatic check_reset(input string nm);
        int nz = 0;
        for (int c = 0; c < NUM_CLASSES; c++) if (similarity_values[c] != 0) nz++;
        check({nm, "_busy"}, busy, 0);
        check({nm, "_rd_en"}, am_rd_en, 0);
        check({nm, "_addr"}, am_rd_addr, 0);
        check({nm, "_idx"}, query_chunk_idx, 0);
        check({nm, "_infer"}, inferring_class, 0);
        check({nm, "_valid"}, result_valid, 0);
        check({nm, "_class"}, result_class, 0);
        check({nm, "_nonzero_sims"}, nz, 0);
    endtask

    task automatic check_result(input string nm, input int ec, input int idx, input int es);
        check({nm, "_valid"}, result_valid, 1);
        check({nm, "_class"}, result_class, ec);
        if (es >= 0) check({nm, "_sim_target"}, similarity_values[idx], es);
        for (int c = 0; c < NUM_CLASSES; c++)
            check($sformatf("%s_sim%0d", nm, c), similarity_values[c], m_sim[c]);
    endtask

    task automatic run_query(input string nm, input int ec, input int idx, input int es);
        int k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        while (!result_valid && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check({nm, "_latency"}, k, 264);
        check_result(nm, ec, idx, es);
        @(posedge clk); #1;
        check({nm, "_valid_drop"}, result_valid, 0);
    endtask

    initial begin
        vecs[0] = '{M_COPY, 7, 0, 7, 5000};
        vecs[1] = '{M_TIE, 3, 12, 3, 5000};
        vecs[2] = '{M_NEAR, 18, 0, 18, 4900};
        vecs[3] = '{M_COPY, 25, 0, 25, 5000};
        vecs[4] = '{M_COPY, 0, 0, 0, 5000};
        vecs[5] = '{M_RAND, 0, 0, -1, -1};

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        nrst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            setup(vecs[i].mode, vecs[i].a, vecs[i].b);
            run_query($sformatf("vec%0d", i), vecs[i].exp_class < 0 ? m_class : vecs[i].exp_class,
                      vecs[i].a, vecs[i].exp_sim);
        end

        // Protocol timing with start held high, then a back-to-back second query.
        setup(M_COPY, 25, 0);
        rd_cnt = 0; first_rd = -1; addr_err = 0; inf_cnt = 0; inf_cyc = -1; rv_cyc = -1; rd2_cyc = -1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (am_rd_en && cyc < 265) begin
                if (first_rd < 0) first_rd = cyc;
                if (am_rd_addr !== ADDR_W'(rd_cnt) || query_chunk_idx !== CHUNK_IDX_W'(rd_cnt % NUM_CHUNKS))
                    addr_err++;
                rd_cnt++;
            end else if (am_rd_en && rd2_cyc < 0) rd2_cyc = cyc;
            if (inferring_class) begin
                inf_cnt++;
                inf_cyc = cyc;
            end
            if (result_valid && rv_cyc < 0) begin
                rv_cyc = cyc;
                check_result("b2b_first", 25, 25, 5000);
            end
            if (cyc == 265) begin
                check("idle_gap_busy", busy, 0);
                setup(M_COPY, 0, 0);
            end
            if (cyc == 266) start = 1'b0;
            @(posedge clk); #1;
        end
        check("rd_count", rd_cnt, 260);
        check("rd_first_cycle", first_rd, 1);
        check("rd_addr_errors", addr_err, 0);
        check("infer_pulses", inf_cnt, 1);
        check("infer_cycle", inf_cyc, 262);
        check("valid_cycle", rv_cyc, 264);
        check("second_start_cycle", rd2_cyc, 266);
        n = 0;
        while (!result_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_result("b2b_second", 0, 0, 5000);
        @(posedge clk); #1;

        // Backpressure: result held while ready is low, starts in DONE ignored.
        setup(M_COPY, 9, 0);
        result_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!result_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_result("bp", 9, 9, 5000);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", result_valid, 1);
            check("bp_hold_class", result_class, 9);
            check("bp_hold_busy", busy, 1);
            check("bp_hold_rd_en", am_rd_en, 0);
            start = (i == 3);
            @(posedge clk); #1;
        end
        result_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bp_after_valid", result_valid, 0);
        check("bp_after_busy", busy, 0);
        @(posedge clk); #1;
        check("bp_start_ignored_busy", busy, 0);
        check("bp_start_ignored_rd_en", am_rd_en, 0);
        check("bp_sims_retained", similarity_values[9], 5000);

        // Reset in the middle of fetching aborts with no result.
        setup(M_COPY, 14, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        check_reset("midrst");
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        stray = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (result_valid || am_rd_en || busy) stray++;
        end
        check("midrst_no_activity", stray, 0);
        setup(M_COPY, 4, 0);
        run_query("after_rst", 4, 4, 5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
